// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } pf_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;
    localparam int          ENTRY_W     = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_prefetch_queue_sync_fifo.sv
// Small synchronous FIFO: head is read straight from the storage registers,
// occupancy is exported so the issue logic can reserve space ahead of time.
module sync_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CW-1:0]    r_count;
    logic             w_pop;
    logic             w_push;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_clear) r_mem[r_wr] <= i_data;
    end

    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch stage: issues in-order word fetches, buffers returned
// instructions with their PCs and throws away stale responses after a redirect.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    input  logic        dec_ready,
    output logic        err_unexpected,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_FLUSH = FLUSH;

    localparam int CW = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);
    localparam int SW = CW + 1;

    logic [1:0]    r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [OW-1:0] r_out;
    logic [OW-1:0] r_drop_cnt;
    logic          r_err;

    logic          w_resp;
    logic          w_fire;
    logic [OW-1:0] w_out_after_redirect;
    logic [SW-1:0] w_occupancy;
    logic [CW-1:0] w_count;
    logic          w_fifo_clear;
    logic          w_fifo_push;
    logic          w_fifo_valid;
    logic [ENTRY_W-1:0] w_fifo_wdata;
    logic [ENTRY_W-1:0] w_fifo_rdata;
    fetch_entry_t  w_head;

    // A response with nothing outstanding is not a real response; it only flags the error.
    assign w_resp = imem_rvalid && (r_out != '0);
    assign w_fire = imem_req && imem_ready;
    assign w_out_after_redirect = r_out - OW'(w_resp);

    // Buffered entries plus in-flight requests never exceed the FIFO depth,
    // which is what guarantees every response a free slot.
    assign w_occupancy = SW'(w_count) + SW'(r_out);

    assign imem_req  = (r_state == ST_RUN) && !redirect_valid &&
                       (w_occupancy < SW'(DEPTH)) && (r_out < OW'(MAX_OUT));
    assign imem_addr = r_fetch_pc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_out      <= '0;
            r_drop_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            if (imem_rvalid && (r_out == '0)) r_err <= 1'b1;
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
                r_resp_pc  <= redirect_pc;
                r_out      <= w_out_after_redirect;
                r_drop_cnt <= w_out_after_redirect;
                r_state    <= (w_out_after_redirect != '0) ? ST_FLUSH : ST_RUN;
            end else begin
                case (r_state)
                    ST_IDLE: r_state <= ST_RUN;
                    ST_RUN: begin
                        if (w_fire) r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
                        if (w_resp) r_resp_pc  <= r_resp_pc + INSTR_BYTES;
                        r_out <= r_out + OW'(w_fire) - OW'(w_resp);
                    end
                    ST_FLUSH: begin
                        if (w_resp) begin
                            r_out      <= r_out - OW'(1);
                            r_drop_cnt <= r_drop_cnt - OW'(1);
                            if (r_drop_cnt == OW'(1)) r_state <= ST_RUN;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_fifo_clear = !reset || redirect_valid;
    assign w_fifo_push  = (r_state == ST_RUN) && w_resp && !redirect_valid;
    assign w_fifo_wdata = {imem_rdata, r_resp_pc};

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .i_clear (w_fifo_clear),
        .i_push  (w_fifo_push),
        .i_data  (w_fifo_wdata),
        .i_pop   (dec_ready),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_rdata),
        .o_count (w_count)
    );

    assign w_head         = w_fifo_rdata;
    assign dec_valid      = w_fifo_valid;
    assign dec_instr      = w_head.instr;
    assign dec_pc         = w_head.pc;
    assign err_unexpected = r_err;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: in-order memory model with tagged stale
// requests plus a queue-level model of the buffered instructions.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_ready = 1'b0;
    logic        err_unexpected;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .MAX_OUT  (MAX_OUT),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .dec_ready      (dec_ready),
        .err_unexpected (err_unexpected),
        .dbg_state      (dbg_state)
    );

    typedef struct { logic [31:0] addr; int due; bit stale; } mem_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;

    mem_t        memq[$];
    ent_t        m_fifo[$];
    logic [31:0] acc_log[$];
    int          acc_cyc[$];
    logic [31:0] pop_log[$];

    bit          m_known = 0;
    bit          m_started = 0;
    bit          m_err = 0;
    logic [31:0] m_fetch_pc = RESET_PC;

    logic        c_reset = 1'b0, c_redirect = 1'b0, c_dec_ready = 1'b1;
    logic        c_ready = 1'b1, c_ready_rand = 1'b0, c_resp_en = 1'b1;
    logic        c_resp_rand = 1'b0, c_force_unexp = 1'b0;
    logic [31:0] c_redirect_pc = '0;
    int          c_lat_max = 1;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;
    bit watch_stale = 0;
    int seen_stale = 0;

    function automatic logic [31:0] instr_of(logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic int stale_cnt();
        int n = 0;
        foreach (memq[i]) if (memq[i].stale) n++;
        return n;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance the model.
    task automatic step();
        logic        rv, rdy, exp_req;
        logic [31:0] rdata;
        logic [1:0]  exp_state;
        mem_t        h;
        bit          have_h;
        @(negedge clk);
        rdy   = c_ready_rand ? 1'($urandom_range(0, 1)) : c_ready;
        rv    = 1'b0;
        rdata = 32'h0;
        if (c_force_unexp && memq.size() == 0) begin
            rv    = 1'b1;
            rdata = $urandom;
        end else if (c_resp_en && memq.size() > 0 && memq[0].due <= cyc &&
                     (!c_resp_rand || $urandom_range(0, 2) != 0)) begin
            rv    = 1'b1;
            rdata = instr_of(memq[0].addr);
        end
        reset          = c_reset;
        redirect_valid = c_redirect;
        redirect_pc    = c_redirect_pc;
        dec_ready      = c_dec_ready;
        imem_ready     = rdy;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        #1;
        exp_req = m_started && (stale_cnt() == 0) && !c_redirect &&
                  (m_fifo.size() + memq.size() < DEPTH) && (memq.size() < MAX_OUT);
        exp_state = !m_started ? 2'd0 : (stale_cnt() != 0) ? 2'd2 : 2'd1;
        if (m_known) begin
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, m_fetch_pc);
            chk("dec_valid", 32'(dec_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) begin
                chk("dec_pc", dec_pc, m_fifo[0].pc);
                chk("dec_instr", dec_instr, m_fifo[0].instr);
            end
            chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
            chk("state", 32'(dbg_state), 32'(exp_state));
        end
        if (watch_stale && dec_valid === 1'b1 && (dec_pc == 32'h10 || dec_pc == 32'h14))
            seen_stale++;

        have_h = 0;
        if (rv) begin
            if (memq.size() == 0) m_err = 1;
            else begin
                h = memq.pop_front();
                have_h = 1;
            end
        end
        if (c_redirect) begin
            m_fifo.delete();
            m_fetch_pc = c_redirect_pc;
            foreach (memq[i]) memq[i].stale = 1;
            m_started = 1;
        end else begin
            if (m_fifo.size() > 0 && c_dec_ready) begin
                pop_log.push_back(m_fifo[0].pc);
                void'(m_fifo.pop_front());
            end
            if (have_h && !h.stale) m_fifo.push_back('{instr_of(h.addr), h.addr});
            if (exp_req && rdy) begin
                memq.push_back('{m_fetch_pc, cyc + $urandom_range(1, c_lat_max), 0});
                acc_log.push_back(m_fetch_pc);
                acc_cyc.push_back(cyc);
                m_fetch_pc = m_fetch_pc + 32'd4;
            end
            m_started = 1;
        end
        if (!c_reset) begin
            memq.delete();
            m_fifo.delete();
            m_started  = 0;
            m_err      = 0;
            m_fetch_pc = RESET_PC;
            m_known    = 1;
        end
        cyc++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, first, n;
        bit ok;

        repeat (3) step();
        chk("reset_dec_valid", 32'(dec_valid), 32'd0);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        chk("reset_err", 32'(err_unexpected), 32'd0);

        // Zero-wait memory, decode always ready.
        c_reset = 1'b1;
        r = cyc;
        first = -1;
        acc_log.delete(); acc_cyc.delete(); pop_log.delete();
        for (int i = 0; i < 12; i++) begin
            step();
            if (first < 0 && dec_valid === 1'b1) first = cyc - 1 - r;
        end
        chk("first_valid_latency", first, 32'd3);
        chk("issue0", at(acc_log, 0), 32'h0);
        chk("issue1", at(acc_log, 1), 32'h4);
        chk("issue2", at(acc_log, 2), 32'h8);
        if (acc_cyc.size() >= 3) begin
            chk("issue_b2b_0", acc_cyc[1] - acc_cyc[0], 32'd1);
            chk("issue_b2b_1", acc_cyc[2] - acc_cyc[1], 32'd1);
        end else chk("issue_count", acc_cyc.size(), 32'd3);
        chk("pop0", at(pop_log, 0), 32'h0);
        chk("pop1", at(pop_log, 1), 32'h4);
        chk("pop2", at(pop_log, 2), 32'h8);

        // Long decode stall.
        c_dec_ready = 1'b0;
        repeat (20) step();
        chk("stall_req_low", 32'(imem_req), 32'd0);
        chk("stall_buffered", m_fifo.size(), DEPTH);
        c_ready = 1'b0;
        c_dec_ready = 1'b1;
        pop_log.delete();
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dec_valid === 1'b1) n++;
        end
        chk("stall_drained", n, DEPTH);
        for (int i = 1; i < pop_log.size(); i++)
            chk("stall_order", pop_log[i] - pop_log[i-1], 32'd4);

        // Two in flight, then redirect before either returns.
        c_resp_en = 1'b0;
        c_ready = 1'b1;
        c_redirect = 1'b1; c_redirect_pc = 32'h10;
        acc_log.delete();
        watch_stale = 1;
        step();
        c_redirect = 1'b0;
        repeat (3) step();
        chk("inflight0", at(acc_log, 0), 32'h10);
        chk("inflight1", at(acc_log, 1), 32'h14);
        chk("inflight_cnt", acc_log.size(), 32'd2);
        c_redirect = 1'b1; c_redirect_pc = 32'h100;
        pop_log.delete();
        step();
        c_redirect = 1'b0;
        step();
        chk("flush_state", 32'(dbg_state), 32'd2);
        c_resp_en = 1'b1;
        for (int i = 0; i < 20 && pop_log.size() == 0; i++) step();
        chk("after_flush_pc", at(pop_log, 0), 32'h100);
        repeat (4) step();
        chk("no_stale_presented", seen_stale, 32'd0);
        watch_stale = 0;

        // Redirect together with a response and a pop while at full credit.
        c_ready = 1'b0; c_resp_en = 1'b1; c_dec_ready = 1'b1;
        repeat (8) step();
        c_redirect = 1'b1; c_redirect_pc = 32'h200;
        step();
        c_redirect = 1'b0;
        c_dec_ready = 1'b0; c_ready = 1'b1; c_resp_en = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            c_resp_en = (memq.size() == MAX_OUT);
            step();
            ok = (m_fifo.size() == 2 && memq.size() == 2);
        end
        chk("setup_reached", 32'(ok), 32'd1);
        c_resp_en = 1'b0;
        step();
        chk("credit_full_req", 32'(imem_req), 32'd0);
        c_resp_en = 1'b1; c_dec_ready = 1'b1;
        c_redirect = 1'b1; c_redirect_pc = 32'h300;
        pop_log.delete();
        step();
        c_redirect = 1'b0; c_resp_en = 1'b0;
        step();
        chk("redir_dec_valid", 32'(dec_valid), 32'd0);
        chk("redir_state", 32'(dbg_state), 32'd2);
        chk("redir_drop", stale_cnt(), 32'd1);
        c_resp_en = 1'b1;
        repeat (10) step();
        chk("redir_back_run", 32'(dbg_state), 32'd1);
        chk("redir_first_pc", at(pop_log, 0), 32'h300);

        // Address wrap at the top of memory.
        c_redirect = 1'b1; c_redirect_pc = 32'hFFFF_FFFC;
        acc_log.delete(); pop_log.delete();
        step();
        c_redirect = 1'b0;
        repeat (10) step();
        chk("wrap_issue0", at(acc_log, 0), 32'hFFFF_FFFC);
        chk("wrap_issue1", at(acc_log, 1), 32'h0000_0000);
        chk("wrap_pop0", at(pop_log, 0), 32'hFFFF_FFFC);
        chk("wrap_pop1", at(pop_log, 1), 32'h0000_0000);

        // Spurious response with nothing outstanding.
        c_ready = 1'b0; c_dec_ready = 1'b0;
        repeat (6) step();
        chk("unexp_before", 32'(err_unexpected), 32'd0);
        n = m_fifo.size();
        c_force_unexp = 1'b1;
        step();
        c_force_unexp = 1'b0;
        repeat (2) step();
        chk("unexp_set", 32'(err_unexpected), 32'd1);
        chk("unexp_fifo_same", m_fifo.size(), n);
        repeat (5) step();
        chk("unexp_sticky", 32'(err_unexpected), 32'd1);

        // Randomized traffic.
        c_ready_rand = 1'b1; c_resp_rand = 1'b1; c_lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            c_dec_ready = ($urandom_range(0, 3) != 0);
            c_redirect  = ($urandom_range(0, 39) == 0);
            c_redirect_pc = ($urandom_range(0, 3) == 0) ?
                            (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4) :
                            ($urandom & 32'hFFFF_FFFC);
            c_reset = ($urandom_range(0, 499) != 0);
            step();
        end

        c_redirect = 1'b0;
        c_reset = 1'b0;
        repeat (2) step();
        chk("final_reset_err", 32'(err_unexpected), 32'd0);
        chk("final_reset_valid", 32'(dec_valid), 32'd0);
        chk("final_reset_req", 32'(imem_req), 32'd0);
        chk("final_reset_state", 32'(dbg_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
